seed_lookup_sched: RTL and testbench

- Controller that sequences short reads from NREQ independent sources through the shared seed-index lookup engine (the per-base A/C/G/T bucket memories).
- Grants sources round-robin and splits the granted read into overlapping seeds.
- Issues one lookup per seed over a req/done handshake, converts the first in-range hit into a reference start index, and returns a tagged result.
- Sits between the read ingress queues and the index/lookup datapath; it only starts granting once the index build phase reports complete.

---
 rtl/seed_lookup_sched_pkg.sv | 21 ++
 rtl/seed_lookup_sched_rr_arbiter.sv | 43 ++++
 rtl/seed_lookup_sched.sv | 139 +++++++++++++
 tb/tb_seed_lookup_sched.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seed_lookup_sched_pkg.sv
// Shared definitions for the seed lookup scheduler: base encodings, FSM states,
// and default read/seed geometry.
package seed_lookup_sched_pkg;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b10;
  localparam logic [1:0] BASE_G = 2'b01;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam int unsigned DEF_READ_W    = 16;
  localparam int unsigned DEF_SEED_W    = 8;
  localparam int unsigned DEF_MAX_START = 80;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EVAL,
    RESULT
  } state_t;

endpackage

// File: rtl/seed_lookup_sched_rr_arbiter.sv
// Round-robin one-hot arbiter: first requester at or after the pointer wins;
// the pointer moves past the winner only when the grant is accepted.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     accept,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     any
);

  localparam int unsigned ID_W = $clog2(NREQ);

  logic [ID_W-1:0] ptr;
  int unsigned     idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept && any) begin
      ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/seed_lookup_sched.sv
// Sequences short reads from NREQ sources through the shared seed-index lookup
// engine, scanning overlapping seeds until the first in-range hit.
module seed_lookup_sched
  import seed_lookup_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned READ_W    = DEF_READ_W,
  parameter int unsigned SEED_W    = DEF_SEED_W,
  parameter int unsigned MAX_START = DEF_MAX_START,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     index_ready,
  input  logic [NREQ-1:0]          rd_valid,
  input  logic [NREQ*READ_W-1:0]   rd_data,
  output logic [NREQ-1:0]          rd_ready,
  output logic                     lk_req,
  output logic [SEED_W-1:0]        lk_seed,
  output logic [1:0]               lk_bucket,
  input  logic                     lk_done,
  input  logic                     lk_hit,
  input  logic [7:0]               lk_pos,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic                     res_found,
  output logic [7:0]               res_index,
  output logic                     res_timeout,
  output logic                     busy
);

  localparam int unsigned ID_W     = $clog2(NREQ);
  localparam int unsigned OFF_W    = $clog2(READ_W) + 1;
  localparam int unsigned CNT_W    = $clog2(TIMEOUT) + 1;
  localparam int unsigned LAST_OFF = READ_W - SEED_W;

  state_t            state;
  logic [READ_W-1:0] read_q;
  logic [OFF_W-1:0]  offset;
  logic [CNT_W-1:0]  cnt;
  logic              hit_q;
  logic [7:0]        pos_q;
  logic              tmo_q;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_id;
  logic              any;
  logic              accept;
  logic [8:0]        cand;
  logic              legal;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (rd_valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  assign accept   = (state == IDLE) && index_ready && any;
  assign rd_ready = accept ? grant : '0;

  assign lk_req      = (state == REQ);
  assign lk_seed     = SEED_W'(read_q >> offset);
  assign lk_bucket   = lk_seed[1:0];
  assign res_valid   = (state == RESULT);
  assign res_timeout = tmo_q;
  assign busy        = (state != IDLE);

  // Start index is evaluated at 9 bits so pos < offset cannot wrap into range.
  assign cand  = {1'b0, pos_q} - 9'(offset);
  assign legal = hit_q && ({1'b0, pos_q} >= 9'(offset)) && (cand <= 9'(MAX_START));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      read_q    <= '0;
      offset    <= '0;
      cnt       <= '0;
      hit_q     <= 1'b0;
      pos_q     <= '0;
      tmo_q     <= 1'b0;
      res_id    <= '0;
      res_found <= 1'b0;
      res_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            read_q <= rd_data[grant_id*READ_W +: READ_W];
            res_id <= grant_id;
            offset <= '0;
            cnt    <= '0;
            tmo_q  <= 1'b0;
            state  <= REQ;
          end
        end
        REQ: begin
          if (lk_done) begin
            hit_q <= lk_hit;
            pos_q <= lk_pos;
            state <= EVAL;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            hit_q <= 1'b0;
            tmo_q <= 1'b1;
            state <= EVAL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        EVAL: begin
          if (legal) begin
            res_found <= 1'b1;
            res_index <= cand[7:0];
            state     <= RESULT;
          end else if (32'(offset) + 2 <= LAST_OFF) begin
            offset <= offset + OFF_W'(2);
            cnt    <= '0;
            state  <= REQ;
          end else begin
            res_found <= 1'b0;
            res_index <= '0;
            state     <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_lookup_sched.sv
// Directed bench for seed_lookup_sched with a scripted lookup-engine responder.
module tb_seed_lookup_sched;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned READ_W = 16;
  localparam int unsigned SEED_W = 8;

  logic                   clk;
  logic                   reset;
  logic                   index_ready;
  logic [NREQ-1:0]        rd_valid;
  logic [NREQ*READ_W-1:0] rd_data;
  logic [NREQ-1:0]        rd_ready;
  logic                   lk_req;
  logic [SEED_W-1:0]      lk_seed;
  logic [1:0]             lk_bucket;
  logic                   lk_done;
  logic                   lk_hit;
  logic [7:0]             lk_pos;
  logic                   res_valid;
  logic                   res_ready;
  logic [1:0]             res_id;
  logic                   res_found;
  logic [7:0]             res_index;
  logic                   res_timeout;
  logic                   busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-seed engine behaviour: 0 miss, 1 hit at resp_pos, 2 never respond.
  int         resp_kind [8];
  logic [7:0] resp_pos  [8];

  seed_lookup_sched #(
    .NREQ      (NREQ),
    .READ_W    (READ_W),
    .SEED_W    (SEED_W),
    .MAX_START (80),
    .TIMEOUT   (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .index_ready (index_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .lk_req      (lk_req),
    .lk_seed     (lk_seed),
    .lk_bucket   (lk_bucket),
    .lk_done     (lk_done),
    .lk_hit      (lk_hit),
    .lk_pos      (lk_pos),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_found   (res_found),
    .res_index   (res_index),
    .res_timeout (res_timeout),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_resp();
    for (int i = 0; i < 8; i++) begin
      resp_kind[i] = 0;
      resp_pos[i]  = 8'd0;
    end
  endtask

  task automatic set_resp(input int seed, input int kind, input logic [7:0] pos);
    resp_kind[seed] = kind;
    resp_pos[seed]  = pos;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Runs the lookup phase after a grant edge until res_valid or the budget expires.
  task automatic serve(input logic [15:0] data, output int n_lk, output int lat);
    int guard;
    int cyc;
    logic [7:0] exp_seed;
    n_lk  = 0;
    lat   = 0;
    guard = 0;
    while (!res_valid && guard < 1000 && n_lk < 8) begin
      if (lk_req) begin
        exp_seed = 8'(data >> (2 * n_lk));
        check("lk_seed", 32'(lk_seed), 32'(exp_seed));
        check("lk_bucket", 32'(lk_bucket), 32'(exp_seed[1:0]));
        if (resp_kind[n_lk] == 2) begin
          cyc = 0;
          while (lk_req && cyc < 200) begin
            tick();
            cyc++;
            lat++;
          end
          check("timeout_cycles", 32'(cyc), 32'd64);
          // Stray response after the abort must not be taken as a result.
          lk_done = 1'b1;
          lk_hit  = 1'b1;
          lk_pos  = 8'd0;
          tick();
          lat++;
          lk_done = 1'b0;
          lk_hit  = 1'b0;
        end else begin
          lk_done = 1'b1;
          lk_hit  = (resp_kind[n_lk] == 1);
          lk_pos  = resp_pos[n_lk];
          tick();
          lat++;
          lk_done = 1'b0;
          lk_hit  = 1'b0;
        end
        n_lk++;
      end else begin
        tick();
        lat++;
        guard++;
      end
    end
    check("res_valid_wait", 32'(res_valid), 32'd1);
  endtask

  task automatic run_read(input int src, input logic [15:0] data, input logic drop_ir,
                          output int n_lk, output int lat);
    int slat;
    rd_valid = '0;
    rd_valid[src] = 1'b1;
    rd_data[src*READ_W +: READ_W] = data;
    #1;
    check("grant", 32'(rd_ready), 32'(1) << src);
    tick();
    rd_valid = '0;
    if (drop_ir) index_ready = 1'b0;
    serve(data, n_lk, slat);
    lat = slat + 1;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("ack_res_valid", 32'(res_valid), 32'd0);
  endtask

  task automatic rr_sequence(input logic [3:0] valid, input int n, input int exp0,
                             input int exp1, input int exp2, input int exp3, input int exp4);
    int exp_id [5];
    int id;
    int wait_cyc;
    int n_lk;
    int lat;
    exp_id[0] = exp0; exp_id[1] = exp1; exp_id[2] = exp2; exp_id[3] = exp3; exp_id[4] = exp4;
    clear_resp();
    set_resp(0, 1, 8'd5);
    rd_data  = {4{16'h0F0F}};
    rd_valid = valid;
    for (int k = 0; k < n; k++) begin
      wait_cyc = 0;
      #1;
      while (rd_ready == '0 && wait_cyc < 10) begin
        tick();
        wait_cyc++;
      end
      id = -1;
      for (int b = 0; b < NREQ; b++) if (rd_ready[b]) id = b;
      check("rr_grant", 32'(id), 32'(exp_id[k]));
      tick();
      serve(16'h0F0F, n_lk, lat);
      check("rr_res_id", 32'(res_id), 32'(exp_id[k]));
      ack();
    end
    rd_valid = '0;
  endtask

  initial begin
    int n_lk;
    int lat;

    reset       = 1'b1;
    index_ready = 1'b0;
    rd_valid    = '0;
    rd_data     = '0;
    lk_done     = 1'b0;
    lk_hit      = 1'b0;
    lk_pos      = 8'd0;
    res_ready   = 1'b0;
    clear_resp();

    do_reset();
    check("rst_lk_req", 32'(lk_req), 32'd0);
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_found", 32'(res_found), 32'd0);
    check("rst_res_index", 32'(res_index), 32'd0);
    check("rst_res_timeout", 32'(res_timeout), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);

    // index_ready low: no grant even with every source valid
    rd_valid = '1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("noidx_rd_ready", 32'(rd_ready), 32'd0);
      tick();
      check("noidx_busy", 32'(busy), 32'd0);
    end
    rd_valid    = '0;
    index_ready = 1'b1;

    // First seed hit, minimum latency, result held while res_ready low
    clear_resp();
    set_resp(0, 1, 8'd20);
    run_read(0, 16'hA5C3, 1'b0, n_lk, lat);
    check("t1_id", 32'(res_id), 32'd0);
    check("t1_found", 32'(res_found), 32'd1);
    check("t1_index", 32'(res_index), 32'd20);
    check("t1_timeout", 32'(res_timeout), 32'd0);
    check("t1_lookups", 32'(n_lk), 32'd1);
    check("t1_latency", 32'(lat), 32'd3);
    tick();
    check("t1_hold_valid", 32'(res_valid), 32'd1);
    check("t1_hold_index", 32'(res_index), 32'd20);
    check("t1_hold_lk_req", 32'(lk_req), 32'd0);
    ack();

    // Miss, hit with pos < offset rejected, then hit 50 at offset 4
    clear_resp();
    set_resp(1, 1, 8'd1);
    set_resp(2, 1, 8'd50);
    run_read(1, 16'h1B6E, 1'b0, n_lk, lat);
    check("t2_id", 32'(res_id), 32'd1);
    check("t2_found", 32'(res_found), 32'd1);
    check("t2_index", 32'(res_index), 32'd46);
    check("t2_lookups", 32'(n_lk), 32'd3);
    ack();

    // All seeds miss; index_ready drops mid-read without aborting it
    clear_resp();
    run_read(3, 16'hC3A5, 1'b1, n_lk, lat);
    check("t3_id", 32'(res_id), 32'd3);
    check("t3_found", 32'(res_found), 32'd0);
    check("t3_index", 32'(res_index), 32'd0);
    check("t3_lookups", 32'(n_lk), 32'd5);
    check("t3_timeout", 32'(res_timeout), 32'd0);
    ack();
    index_ready = 1'b1;

    // Engine silent on seed 0: abort after 64 cycles, seed at offset 2 hits pos 10
    clear_resp();
    set_resp(0, 2, 8'd0);
    set_resp(1, 1, 8'd10);
    run_read(2, 16'h5A3C, 1'b0, n_lk, lat);
    check("t4_id", 32'(res_id), 32'd2);
    check("t4_timeout", 32'(res_timeout), 32'd1);
    check("t4_found", 32'(res_found), 32'd1);
    check("t4_index", 32'(res_index), 32'd8);
    check("t4_lookups", 32'(n_lk), 32'd2);
    ack();

    // MAX_START boundary: cand 90 and 81 rejected, cand 80 accepted
    clear_resp();
    set_resp(0, 1, 8'd90);
    set_resp(1, 1, 8'd83);
    set_resp(2, 1, 8'd84);
    run_read(0, 16'hE417, 1'b0, n_lk, lat);
    check("t5_found", 32'(res_found), 32'd1);
    check("t5_index", 32'(res_index), 32'd80);
    check("t5_lookups", 32'(n_lk), 32'd3);
    check("t5_timeout", 32'(res_timeout), 32'd0);
    ack();

    // Round-robin order from a fresh pointer
    do_reset();
    rr_sequence(4'b1111, 5, 0, 1, 2, 3, 0);
    do_reset();
    rr_sequence(4'b1011, 4, 0, 1, 3, 0, 0);

    // Reset while a lookup is outstanding; a late lk_done is ignored
    clear_resp();
    rd_valid    = 4'b0001;
    rd_data     = {4{16'h3C3C}};
    tick();
    rd_valid = '0;
    check("rst_mid_req_before", 32'(lk_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_lk_req", 32'(lk_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    lk_done = 1'b1;
    lk_hit  = 1'b1;
    lk_pos  = 8'd3;
    tick();
    lk_done = 1'b0;
    lk_hit  = 1'b0;
    check("late_done_busy", 32'(busy), 32'd0);
    check("late_done_res_valid", 32'(res_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
